// File: rtl/memory_burst.sv
// memory_burst: word-addressed memory with 1/4/8/16-word read/write bursts,
// registered read data with per-beat valid, and out-of-range error flagging.
module memory_burst #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_WORDS = 262144,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(32'h80020000)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            access_size,
  input  logic                  rw,
  input  logic                  enable,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  err
);
  localparam int IW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;
  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_left;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid, r_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [4:0]            w_len;
  logic                  w_beat, w_rd, w_in_range;
  logic [ADDR_WIDTH-1:0] w_addr, w_word, w_off;
  logic [IW-1:0]         w_idx;
  // Beat 0 runs straight off the request inputs; later beats use the latched address.
  always_comb begin
    w_len = access_size == 2'd0 ? 5'd1 : access_size == 2'd1 ? 5'd4 : access_size == 2'd2 ? 5'd8 : 5'd16;
    w_beat = (r_state != IDLE) || enable;
    w_rd = r_state == IDLE ? rw : r_state == RD_BURST;
    w_addr = r_state == IDLE ? address : r_addr;
    w_word = {w_addr[ADDR_WIDTH-1:2], 2'b00};
    w_off = w_word - START_ADDR;
    w_in_range = (w_word >= START_ADDR) && ((w_off >> 2) < ADDR_WIDTH'(DEPTH_WORDS));
    w_idx = w_off[IW+1:2];
    w_next = r_state;
    if (r_state == IDLE) begin
      if (enable && w_len != 5'd1) w_next = rw ? RD_BURST : WR_BURST;
    end else if (r_left == 4'd1) begin
      w_next = IDLE;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_left <= '0;
      r_data_out <= '0;
      r_valid <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_beat) r_addr <= w_addr + ADDR_WIDTH'(4);
      if (r_state == IDLE) begin
        if (enable) r_left <= 4'(w_len - 5'd1);
      end else begin
        r_left <= r_left - 4'd1;
      end
      if (w_beat && w_rd) r_data_out <= w_in_range ? r_mem[w_idx] : '0;
      r_valid <= w_beat && w_rd;
      r_err <= w_beat && !w_in_range;
    end
  end
  // Gating on reset_n keeps an edge during reset from writing a stray beat.
  always_ff @(posedge clock) begin
    if (reset_n && w_beat && !w_rd && w_in_range) r_mem[w_idx] <= data_in;
  end
  assign busy = r_state != IDLE;
  assign data_out = r_data_out;
  assign data_valid = r_valid;
  assign err = r_err;
endmodule

// File: tb/tb_memory_burst.sv
// tb_memory_burst: directed self-checking bench for memory_burst.
module tb_memory_burst;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic [1:0]  access_size = '0;
  logic        rw = 1'b0;
  logic        enable = 1'b0;
  logic        busy, data_valid, err;
  logic [31:0] data_out;
  int n_checks = 0;
  int n_fail = 0;

  memory_burst dut (
    .clock(clock), .reset_n(reset_n), .address(address), .data_in(data_in),
    .access_size(access_size), .rw(rw), .enable(enable), .busy(busy),
    .data_out(data_out), .data_valid(data_valid), .err(err)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    #3;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_out); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    #9 reset_n = 1'b1;
  endtask

  task automatic test_single;
    address = 32'h80020000; data_in = 32'h2408000A; access_size = 2'b00; rw = 1'b0; enable = 1'b1;
    tick;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_wr_busy: got %b want 0", busy); end
    rw = 1'b1;
    tick;
    enable = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_rd_busy: got %b want 0", busy); end
    n_checks++; if (data_out !== 32'h2408000A) begin n_fail++; $display("FAIL single_rd_data: got %h want 2408000a", data_out); end
    n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL single_rd_valid: got %b want 1", data_valid); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_rd_err: got %b want 0", err); end
    tick;
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_valid: got %b want 0", data_valid); end
  endtask

  task automatic test_burst4;
    int bc;
    address = 32'h80020010; access_size = 2'b01; rw = 1'b0; enable = 1'b1; bc = 0;
    for (int i = 0; i < 4; i++) begin
      data_in = 32'h11 * (i + 1);
      tick;
      enable = 1'b0;
      if (busy) bc++;
    end
    n_checks++; if (bc !== 3) begin n_fail++; $display("FAIL b4_wr_busy_cycles: got %0d want 3", bc); end
    rw = 1'b1; enable = 1'b1; bc = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      enable = 1'b0;
      if (busy) bc++;
      n_checks++; if (data_out !== 32'h11 * (i + 1)) begin n_fail++; $display("FAIL b4_rd_data beat %0d: got %h want %h", i, data_out, 32'h11 * (i + 1)); end
      n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL b4_rd_valid beat %0d: got %b want 1", i, data_valid); end
    end
    n_checks++; if (bc !== 3) begin n_fail++; $display("FAIL b4_rd_busy_cycles: got %0d want 3", bc); end
    tick;
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL b4_after_valid: got %b want 0", data_valid); end
  endtask

  task automatic test_err;
    address = 32'h8001FFFC; access_size = 2'b00; rw = 1'b1; enable = 1'b1;
    tick;
    enable = 1'b0;
    n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL low_rd_data: got %h want 0", data_out); end
    n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL low_rd_valid: got %b want 1", data_valid); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL low_rd_err: got %b want 1", err); end
    tick;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL low_after_err: got %b want 0", err); end
    address = 32'h8011FFF0; access_size = 2'b01; rw = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 32'h100 + i;
      tick;
      enable = 1'b0;
    end
    access_size = 2'b11; rw = 1'b1; enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick;
      enable = 1'b0;
      n_checks++; if (err !== (i >= 4)) begin n_fail++; $display("FAIL top_rd_err beat %0d: got %b want %b", i, err, i >= 4); end
      n_checks++; if (data_out !== (i < 4 ? 32'h100 + i : 32'h0)) begin n_fail++; $display("FAIL top_rd_data beat %0d: got %h want %h", i, data_out, i < 4 ? 32'h100 + i : 32'h0); end
      n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL top_rd_valid beat %0d: got %b want 1", i, data_valid); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL top_end_busy: got %b want 0", busy); end
    tick;
    n_checks++; if (err !== 1'b0 || data_valid !== 1'b0) begin n_fail++; $display("FAIL top_after: got err=%b valid=%b want 0 0", err, data_valid); end
  endtask

  task automatic test_busy_ignore;
    address = 32'h80020010; access_size = 2'b10; rw = 1'b1; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (i == 0) begin address = 32'h80020010; rw = 1'b0; data_in = 32'hDEAD; access_size = 2'b00; enable = 1'b1; end
      if (i == 7) enable = 1'b0;
      n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL ign_rd_valid beat %0d: got %b want 1", i, data_valid); end
      if (i < 4) begin
        n_checks++; if (data_out !== 32'h11 * (i + 1)) begin n_fail++; $display("FAIL ign_rd_data beat %0d: got %h want %h", i, data_out, 32'h11 * (i + 1)); end
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_end_busy: got %b want 0", busy); end
    address = 32'h80020010; access_size = 2'b00; rw = 1'b1; enable = 1'b1;
    tick;
    enable = 1'b0;
    n_checks++; if (data_out !== 32'h11) begin n_fail++; $display("FAIL ign_target: got %h want 00000011", data_out); end
  endtask

  task automatic test_reset_mid;
    address = 32'h80020100; access_size = 2'b10; rw = 1'b0; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 32'h50 + i;
      tick;
      enable = 1'b0;
    end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 32'hA0 + i;
      tick;
      enable = 1'b0;
    end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    data_in = 32'hA3;
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_reset: got %b want 0", busy); end
    n_checks++; if (data_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL mid_flags_reset: got valid=%b err=%b want 0 0", data_valid, err); end
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    address = 32'h80020100; access_size = 2'b10; rw = 1'b1; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      enable = 1'b0;
      n_checks++; if (data_out !== (i < 3 ? 32'hA0 + i : 32'h50 + i)) begin n_fail++; $display("FAIL mid_readback word %0d: got %h want %h", i, data_out, i < 3 ? 32'hA0 + i : 32'h50 + i); end
    end
  endtask

  task automatic test_unaligned;
    address = 32'h80020003; access_size = 2'b00; rw = 1'b0; data_in = 32'h66; enable = 1'b1;
    tick;
    address = 32'h80020000; rw = 1'b1;
    tick;
    enable = 1'b0;
    n_checks++; if (data_out !== 32'h66 || data_valid !== 1'b1) begin n_fail++; $display("FAIL unaligned: got data=%h valid=%b want 00000066 1", data_out, data_valid); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_burst4;
    test_err;
    test_busy_ignore;
    test_reset_mid;
    test_unaligned;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
